// File: rtl/pipe_if_fetch_if.sv
// pipe_if_fetch_if: one-outstanding req/ack channel between fetch stage and instruction memory
interface pipe_if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  modport master(output imem_req, imem_addr, input imem_rdata, imem_ack);
  modport slave(input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/pipe_if_fetch.sv
// pipe_if_fetch: fetch PC, variable-latency imem fetch, stall hold buffer and IF/ID register
module pipe_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [1:0]      pcsource,
  input  logic [31:0]     bpc,
  input  logic [31:0]     rpc,
  input  logic [31:0]     jpc,
  input  logic            nostall,
  pipe_if_fetch_if.master imem,
  output logic [31:0]     dpc4,
  output logic [31:0]     inst,
  output logic            dvalid
);
  logic        r_run, r_hold_v, r_rdir_v, r_dvalid;
  logic [31:0] r_pc, r_hold_inst, r_hold_pc4, r_rdir_pc, r_dpc4, r_inst;
  logic        w_req, w_done, w_redir;
  logic [31:0] w_pc4, w_tgt_raw, w_tgt;
  assign w_req          = r_run & ~r_hold_v;
  assign w_done         = w_req & imem.imem_ack;
  assign w_redir        = nostall & r_dvalid & (pcsource != 2'b00);
  assign w_pc4          = r_pc + 32'd4;
  assign w_tgt_raw      = pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? rpc : jpc;
  assign w_tgt          = w_tgt_raw & ~32'd3;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign dpc4           = r_dpc4;
  assign inst           = r_inst;
  assign dvalid         = r_dvalid;
  // fetching starts one cycle after reset releases
  always_ff @(posedge clk) begin
    r_run <= clrn;
  end
  // fetch PC: a redirect replaces the next pc unless the delay-slot fetch is still pending
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_pc      <= RESET_PC;
      r_rdir_v  <= 1'b0;
      r_rdir_pc <= RESET_PC;
    end else if (w_redir && !r_rdir_v && (r_hold_v || w_done)) begin
      r_pc <= w_tgt;
    end else if (w_redir && !r_rdir_v) begin
      r_rdir_v  <= 1'b1;
      r_rdir_pc <= w_tgt;
    end else if (w_done) begin
      r_pc     <= r_rdir_v ? r_rdir_pc : w_pc4;
      r_rdir_v <= 1'b0;
    end
  end
  // park a word fetched while decode stalls; it drains before the next request
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_hold_v <= 1'b0;
    end else if (w_done && !nostall) begin
      r_hold_v    <= 1'b1;
      r_hold_inst <= imem.imem_rdata;
      r_hold_pc4  <= w_pc4;
    end else if (nostall) begin
      r_hold_v <= 1'b0;
    end
  end
  // IF/ID register: held word first, then the word just fetched, otherwise a bubble
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_dvalid <= 1'b0;
      r_inst   <= NOP_INST;
      r_dpc4   <= 32'd0;
    end else if (nostall) begin
      r_dvalid <= r_hold_v | w_done;
      r_inst   <= r_hold_v ? r_hold_inst : w_done ? imem.imem_rdata : NOP_INST;
      r_dpc4   <= r_hold_v ? r_hold_pc4 : w_done ? w_pc4 : r_dpc4;
    end
  end
endmodule
